// File: rtl/axis_loopback_fifo.sv
// rtl/axis_loopback_fifo.sv - FWFT AXI-Stream loopback FIFO with optional store-and-forward release
module axis_loopback_fifo #(
   parameter int c_WIDTH     = 8,
   parameter int c_DEPTH     = 16,
   parameter int c_STORE_FWD = 0
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic [c_WIDTH-1:0]         s_axis_tdata,
   input  logic                       s_axis_tvalid,
   output logic                       s_axis_tready,
   input  logic                       s_axis_tlast,
   output logic [c_WIDTH-1:0]         m_axis_tdata,
   output logic                       m_axis_tvalid,
   input  logic                       m_axis_tready,
   output logic                       m_axis_tlast,
   output logic [$clog2(c_DEPTH):0]   fill_level,
   output logic [$clog2(c_DEPTH):0]   pkts_stored,
   output logic [31:0]                pkt_total
);

   localparam int AW = $clog2(c_DEPTH);
   localparam int CW = AW + 1;
   localparam logic [CW-1:0] FULL = CW'(c_DEPTH);

   logic [c_WIDTH:0]  mem [c_DEPTH];
   logic [AW-1:0]     wr_ptr;
   logic [AW-1:0]     rd_ptr;
   logic              full;
   logic              wr_en;
   logic              rd_en;
   logic              wr_last;
   logic              rd_last;
   logic              cut_thru;
   logic              release_ok;

   assign full          = (fill_level == FULL);
   assign s_axis_tready = rst & ~full;

   // Store-and-forward holds the head back until a whole packet is present; a packet that
   // fills the FIFO without tlast streams out until its tlast leaves, so it cannot deadlock.
   assign release_ok    = (c_STORE_FWD == 0) || (pkts_stored != '0) || full || cut_thru;
   assign m_axis_tvalid = rst & (fill_level != '0) & release_ok;

   assign {m_axis_tlast, m_axis_tdata} = mem[rd_ptr];

   assign wr_en   = s_axis_tvalid & s_axis_tready;
   assign rd_en   = m_axis_tvalid & m_axis_tready;
   assign wr_last = wr_en & s_axis_tlast;
   assign rd_last = rd_en & m_axis_tlast;

   always_ff @(posedge clk) begin
      if (wr_en)
         mem[wr_ptr] <= {s_axis_tlast, s_axis_tdata};
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_ptr      <= '0;
         rd_ptr      <= '0;
         fill_level  <= '0;
         pkts_stored <= '0;
         pkt_total   <= '0;
         cut_thru    <= 1'b0;
      end else begin
         if (wr_en)
            wr_ptr <= wr_ptr + 1'b1;
         if (rd_en)
            rd_ptr <= rd_ptr + 1'b1;

         case ({wr_en, rd_en})
            2'b10:   fill_level <= fill_level + 1'b1;
            2'b01:   fill_level <= fill_level - 1'b1;
            default: fill_level <= fill_level;
         endcase

         case ({wr_last, rd_last})
            2'b10:   pkts_stored <= pkts_stored + 1'b1;
            2'b01:   pkts_stored <= pkts_stored - 1'b1;
            default: pkts_stored <= pkts_stored;
         endcase

         if (wr_last)
            pkt_total <= pkt_total + 32'd1;

         if (rd_last)
            cut_thru <= 1'b0;
         else if (full)
            cut_thru <= 1'b1;
      end
   end

endmodule

// File: tb/tb_axis_loopback_fifo.sv
// tb/tb_axis_loopback_fifo.sv - directed and randomized checks for axis_loopback_fifo
module tb_axis_loopback_fifo;

   logic       clk = 1'b0;
   logic       rst = 1'b0;

   logic [7:0] a_s_data = '0;
   logic       a_s_valid = 1'b0, a_s_last = 1'b0, a_s_ready;
   logic [7:0] a_m_data;
   logic       a_m_valid, a_m_last, a_m_ready = 1'b0;
   logic [4:0] a_fill, a_pkts;
   logic [31:0] a_total;

   logic [7:0] b_s_data = '0;
   logic       b_s_valid = 1'b0, b_s_last = 1'b0, b_s_ready;
   logic [7:0] b_m_data;
   logic       b_m_valid, b_m_last, b_m_ready = 1'b0;
   logic [4:0] b_fill, b_pkts;
   logic [31:0] b_total;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   axis_loopback_fifo #(.c_WIDTH(8), .c_DEPTH(16), .c_STORE_FWD(0)) u_ct (
      .clk(clk), .rst(rst),
      .s_axis_tdata(a_s_data), .s_axis_tvalid(a_s_valid), .s_axis_tready(a_s_ready),
      .s_axis_tlast(a_s_last),
      .m_axis_tdata(a_m_data), .m_axis_tvalid(a_m_valid), .m_axis_tready(a_m_ready),
      .m_axis_tlast(a_m_last),
      .fill_level(a_fill), .pkts_stored(a_pkts), .pkt_total(a_total)
   );

   axis_loopback_fifo #(.c_WIDTH(8), .c_DEPTH(16), .c_STORE_FWD(1)) u_sf (
      .clk(clk), .rst(rst),
      .s_axis_tdata(b_s_data), .s_axis_tvalid(b_s_valid), .s_axis_tready(b_s_ready),
      .s_axis_tlast(b_s_last),
      .m_axis_tdata(b_m_data), .m_axis_tvalid(b_m_valid), .m_axis_tready(b_m_ready),
      .m_axis_tlast(b_m_last),
      .fill_level(b_fill), .pkts_stored(b_pkts), .pkt_total(b_total)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   logic [8:0] sb[$];
   logic [8:0] exp_beat;
   logic [8:0] prev_beat;
   logic       prev_mv, prev_rd, acc, seen_rise;
   int         sent, rcv, cnt, cur_len, beat_idx, pkts_sent;
   logic [7:0] nxt_data;

   initial begin
      // reset state
      cyc(); cyc();
      #1;
      chk("rst_a_tready", 32'(a_s_ready), 32'd0);
      chk("rst_a_tvalid", 32'(a_m_valid), 32'd0);
      chk("rst_a_fill",   32'(a_fill),    32'd0);
      chk("rst_a_total",  a_total,        32'd0);
      chk("rst_b_tready", 32'(b_s_ready), 32'd0);
      chk("rst_b_tvalid", 32'(b_m_valid), 32'd0);
      cyc();
      rst = 1'b1;
      cyc();
      #1;
      chk("rel_a_tready", 32'(a_s_ready), 32'd1);
      chk("rel_b_tready", 32'(b_s_ready), 32'd1);

      // cut-through, three beats back to back
      cyc();
      a_m_ready = 1'b1;
      a_s_valid = 1'b1; a_s_data = 8'h11; a_s_last = 1'b0;
      #1;
      chk("ct_empty_tvalid", 32'(a_m_valid), 32'd0);
      cyc();
      a_s_data = 8'h22;
      #1;
      chk("ct_b0_valid", 32'(a_m_valid), 32'd1);
      chk("ct_b0_data",  32'(a_m_data),  32'h11);
      chk("ct_b0_last",  32'(a_m_last),  32'd0);
      cyc();
      a_s_data = 8'h33; a_s_last = 1'b1;
      #1;
      chk("ct_b1_data",  32'(a_m_data),  32'h22);
      chk("ct_b1_last",  32'(a_m_last),  32'd0);
      cyc();
      a_s_valid = 1'b0; a_s_last = 1'b0;
      #1;
      chk("ct_b2_data",  32'(a_m_data),  32'h33);
      chk("ct_b2_last",  32'(a_m_last),  32'd1);
      chk("ct_b2_fill",  32'(a_fill),    32'd1);
      cyc();
      #1;
      chk("ct_done_valid", 32'(a_m_valid), 32'd0);
      chk("ct_done_fill",  32'(a_fill),    32'd0);
      chk("ct_done_total", a_total,        32'd1);

      // fill to full, then one read, then simultaneous read+write
      a_m_ready = 1'b0;
      for (int i = 0; i < 16; i++) begin
         a_s_valid = 1'b1; a_s_data = 8'(i); a_s_last = 1'b0;
         cyc();
      end
      a_s_valid = 1'b0;
      #1;
      chk("full_fill",   32'(a_fill),    32'd16);
      chk("full_tready", 32'(a_s_ready), 32'd0);
      chk("full_tvalid", 32'(a_m_valid), 32'd1);
      a_m_ready = 1'b1;
      cyc();
      a_m_ready = 1'b0;
      #1;
      chk("rd1_fill",   32'(a_fill),    32'd15);
      chk("rd1_tready", 32'(a_s_ready), 32'd1);
      chk("rd1_head",   32'(a_m_data),  32'h01);
      a_m_ready = 1'b1;
      a_s_valid = 1'b1; a_s_data = 8'hAA; a_s_last = 1'b1;
      cyc();
      a_s_valid = 1'b0; a_s_last = 1'b0;
      #1;
      chk("rw_fill", 32'(a_fill),   32'd15);
      chk("rw_pkts", 32'(a_pkts),   32'd1);
      chk("rw_head", 32'(a_m_data), 32'h02);
      for (int k = 0; k < 15; k++) begin
         chk("drain_valid", 32'(a_m_valid), 32'd1);
         chk("drain_data",  32'(a_m_data),  (k < 14) ? 32'(k + 2) : 32'hAA);
         chk("drain_last",  32'(a_m_last),  (k < 14) ? 32'd0 : 32'd1);
         cyc();
         #1;
      end
      chk("drain_fill",  32'(a_fill), 32'd0);
      chk("drain_pkts",  32'(a_pkts), 32'd0);
      chk("drain_total", a_total,     32'd2);
      a_m_ready = 1'b0;

      // store-and-forward: held until tlast arrives
      b_m_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         b_s_valid = 1'b1; b_s_data = 8'(8'hC0 + i); b_s_last = (i == 3);
         #1;
         chk("sf_hold_valid", 32'(b_m_valid), 32'd0);
         cyc();
      end
      b_s_valid = 1'b0; b_s_last = 1'b0;
      #1;
      chk("sf_rel_valid", 32'(b_m_valid), 32'd1);
      chk("sf_rel_pkts",  32'(b_pkts),    32'd1);
      for (int i = 0; i < 4; i++) begin
         chk("sf_out_data", 32'(b_m_data), 32'(8'hC0 + i));
         chk("sf_out_last", 32'(b_m_last), (i == 3) ? 32'd1 : 32'd0);
         cyc();
         #1;
      end
      chk("sf_out_empty", 32'(b_m_valid), 32'd0);

      // store-and-forward oversize packet of 20 beats
      sent = 0; rcv = 0; cnt = 0; seen_rise = 1'b0;
      while (rcv < 20 && cnt < 200) begin
         b_s_valid = (sent < 20);
         b_s_data  = 8'(8'h40 + sent);
         b_s_last  = (sent == 19);
         #1;
         if (b_m_valid && !seen_rise) begin
            seen_rise = 1'b1;
            chk("ov_rise_fill", 32'(b_fill), 32'd16);
         end
         if (b_m_valid && b_m_ready) begin
            chk("ov_data", 32'(b_m_data), 32'(8'h40 + rcv));
            chk("ov_last", 32'(b_m_last), (rcv == 19) ? 32'd1 : 32'd0);
            rcv++;
         end
         if (b_s_valid && b_s_ready)
            sent++;
         cyc();
         cnt++;
      end
      b_s_valid = 1'b0; b_s_last = 1'b0;
      chk("ov_count", 32'(rcv), 32'd20);
      #1;
      chk("ov_fill", 32'(b_fill), 32'd0);

      // random valid/ready traffic against a scoreboard
      pkts_sent = 0; beat_idx = 0; cur_len = $urandom_range(1, 6);
      nxt_data = 8'($urandom); acc = 1'b0; prev_mv = 1'b0; prev_rd = 1'b0;
      prev_beat = '0; cnt = 0;
      while ((pkts_sent < 1000 || sb.size() > 0) && cnt < 60000) begin
         if (acc)
            b_s_valid = 1'b0;
         acc = 1'b0;
         if (!b_s_valid && pkts_sent < 1000)
            b_s_valid = 1'($urandom_range(0, 1));
         b_s_data  = nxt_data;
         b_s_last  = (beat_idx == cur_len - 1);
         b_m_ready = 1'($urandom_range(0, 1));
         #1;
         if (prev_mv && !prev_rd) begin
            chk("rnd_hold_valid", 32'(b_m_valid), 32'd1);
            chk("rnd_hold_beat",  32'({b_m_last, b_m_data}), 32'(prev_beat));
         end
         if (b_m_valid && b_m_ready) begin
            if (sb.size() == 0) begin
               chk("rnd_spurious", 32'd1, 32'd0);
            end else begin
               exp_beat = sb.pop_front();
               chk("rnd_beat", 32'({b_m_last, b_m_data}), 32'(exp_beat));
            end
         end
         if (b_s_valid && b_s_ready) begin
            sb.push_back({b_s_last, b_s_data});
            acc = 1'b1;
            nxt_data = 8'($urandom);
            if (b_s_last) begin
               pkts_sent++;
               beat_idx = 0;
               cur_len = $urandom_range(1, 6);
            end else begin
               beat_idx++;
            end
         end
         prev_mv   = b_m_valid;
         prev_rd   = b_m_valid & b_m_ready;
         prev_beat = {b_m_last, b_m_data};
         cyc();
         cnt++;
      end
      b_s_valid = 1'b0; b_s_last = 1'b0; b_m_ready = 1'b0;
      chk("rnd_timeout", 32'(cnt < 60000), 32'd1);
      chk("rnd_sb_empty", 32'(sb.size()), 32'd0);
      chk("rnd_total", b_total, 32'd1002);

      // mid-stream asynchronous reset
      a_m_ready = 1'b0;
      for (int i = 0; i < 5; i++) begin
         a_s_valid = 1'b1; a_s_data = 8'(8'h70 + i); a_s_last = (i == 2);
         cyc();
      end
      #1;
      chk("mid_pre_fill", 32'(a_fill), 32'd5);
      rst = 1'b0;
      #1;
      chk("mid_tready", 32'(a_s_ready), 32'd0);
      chk("mid_tvalid", 32'(a_m_valid), 32'd0);
      chk("mid_fill",   32'(a_fill),    32'd0);
      chk("mid_pkts",   32'(a_pkts),    32'd0);
      chk("mid_total",  a_total,        32'd0);
      chk("mid_b_total", b_total,       32'd0);
      a_s_valid = 1'b0; a_s_last = 1'b0;
      cyc();
      rst = 1'b1;
      cyc();
      #1;
      chk("post_tready", 32'(a_s_ready), 32'd1);
      chk("post_tvalid", 32'(a_m_valid), 32'd0);
      chk("post_fill",   32'(a_fill),    32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
